// File: rtl/image_buffer_if.sv
// Pixel buffer bus: renderer-side write/clear controls and scan-out read port.
// The master drives requests; the image_buffer (slave) returns read data and status.
interface image_buffer_if #(
  parameter int ROW_W = 7,
  parameter int COL_W = 7,
  parameter int PIX_W = 1
);
  logic             rd_en;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [PIX_W-1:0] data;
  logic             data_valid;
  logic             we;
  logic [ROW_W-1:0] rowW;
  logic [COL_W-1:0] colW;
  logic [PIX_W-1:0] dataW;
  logic             clr;
  logic             busy;
  logic             swap;
  logic             bank;

  modport master (
    output rd_en, row, col, we, rowW, colW, dataW, clr, swap,
    input  data, data_valid, busy, bank
  );

  modport slave (
    input  rd_en, row, col, we, rowW, colW, dataW, clr, swap,
    output data, data_valid, busy, bank
  );
endinterface

// File: rtl/image_buffer.sv
// Parametrised single-clock framebuffer with registered read, bounds checking and clear engine.
// Define DBUF_EN to build two banks (display bank read, back bank written) with a swap control.
module image_buffer #(
  parameter int               ROWS    = 80,
  parameter int               COLS    = 128,
  parameter int               PIX_W   = 1,
  parameter int               ROW_W   = 7,
  parameter int               COL_W   = 7,
  parameter logic [PIX_W-1:0] CLR_VAL = '0
) (
  input logic            clk,
  input logic            rst_n,
  image_buffer_if.slave  bus
);

  localparam int DEPTH  = ROWS * COLS;
  localparam int ADDR_W = $clog2(DEPTH);
`ifdef DBUF_EN
  localparam int BANKS  = 2;
`else
  localparam int BANKS  = 1;
`endif
  localparam int MEM_AW = $clog2(BANKS * DEPTH);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam logic [MEM_AW-1:0] BANK_OFFSET = MEM_AW'(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, nextState;
  logic [ADDR_W-1:0] clrAddr, nextClrAddr;

  logic [PIX_W-1:0]  mem [BANKS*DEPTH];

  logic              busy;
  logic              clrLast;
  logic              rdBank, wrBank;
  logic              rdInRange, wrInRange;
  logic              userWe;
  logic [ADDR_W-1:0] rdAddr, wrAddr;
  logic [MEM_AW-1:0] rdIdx, wrIdx, clrIdx;
  logic [PIX_W-1:0]  dataReg;
  logic              validReg;

  assign rdInRange = (32'(bus.row)  < 32'(ROWS)) && (32'(bus.col)  < 32'(COLS));
  assign wrInRange = (32'(bus.rowW) < 32'(ROWS)) && (32'(bus.colW) < 32'(COLS));

  assign rdAddr = ADDR_W'(32'(bus.row)  * 32'(COLS) + 32'(bus.col));
  assign wrAddr = ADDR_W'(32'(bus.rowW) * 32'(COLS) + 32'(bus.colW));

  assign rdIdx  = MEM_AW'(rdAddr)  + (rdBank ? BANK_OFFSET : '0);
  assign wrIdx  = MEM_AW'(wrAddr)  + (wrBank ? BANK_OFFSET : '0);
  assign clrIdx = MEM_AW'(clrAddr) + (wrBank ? BANK_OFFSET : '0);

  assign busy    = (state == CLEAR);
  assign clrLast = busy && (clrAddr == LAST_ADDR);
  assign userWe  = bus.we && wrInRange && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clrAddr <= '0;
    end else begin
      state   <= nextState;
      clrAddr <= nextClrAddr;
    end
  end

  // The counter stops on the last address rather than wrapping.
  always_comb begin
    nextState   = state;
    nextClrAddr = clrAddr;
    case (state)
      IDLE: begin
        if (bus.clr) begin
          nextState   = CLEAR;
          nextClrAddr = '0;
        end
      end
      CLEAR: begin
        if (clrAddr == LAST_ADDR) begin
          nextState = IDLE;
        end else begin
          nextClrAddr = clrAddr + ADDR_W'(1);
        end
      end
      default: nextState = IDLE;
    endcase
  end

`ifdef DBUF_EN
  logic bankReg;
  logic swapPending;

  // Swaps requested during a clear wait for the edge on which busy falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bankReg     <= 1'b0;
      swapPending <= 1'b0;
    end else if (!busy) begin
      if (bus.swap) bankReg <= ~bankReg;
    end else if (clrLast) begin
      if (swapPending || bus.swap) bankReg <= ~bankReg;
      swapPending <= 1'b0;
    end else if (bus.swap) begin
      swapPending <= 1'b1;
    end
  end

  assign rdBank   = bankReg;
  assign wrBank   = ~bankReg;
  assign bus.bank = bankReg;
`else
  logic unusedSwap;

  assign unusedSwap = bus.swap;
  assign rdBank     = 1'b0;
  assign wrBank     = 1'b0;
  assign bus.bank   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clrIdx] <= CLR_VAL;
    end else if (userWe) begin
      mem[wrIdx] <= bus.dataW;
    end
  end

  // Write-first: a same-cycle user write to the read address is forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataReg  <= '0;
      validReg <= 1'b0;
    end else begin
      validReg <= bus.rd_en;
      if (bus.rd_en) begin
        if (!rdInRange) begin
          dataReg <= '0;
        end else if (userWe && (wrIdx == rdIdx)) begin
          dataReg <= bus.dataW;
        end else begin
          dataReg <= mem[rdIdx];
        end
      end
    end
  end

  assign bus.data       = dataReg;
  assign bus.data_valid = validReg;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_image_buffer.sv
// Self-checking bench for image_buffer: scoreboard of expected reads plus a
// reference pixel/clear/bank model advanced once per clock.
module tb_image_buffer;

  localparam int               ROWS    = 80;
  localparam int               COLS    = 128;
  localparam int               PIX_W   = 1;
  localparam int               ROW_W   = 7;
  localparam int               COL_W   = 7;
  localparam logic [PIX_W-1:0] CLR_VAL = '0;
  localparam int               DEPTH   = ROWS * COLS;

  typedef struct packed {
    logic             v;
    logic [PIX_W-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  image_buffer_if #(.ROW_W(ROW_W), .COL_W(COL_W), .PIX_W(PIX_W)) bus ();

  image_buffer #(
    .ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W),
    .ROW_W(ROW_W), .COL_W(COL_W), .CLR_VAL(CLR_VAL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t             expQ[$];
  logic [PIX_W-1:0] model [2*DEPTH];
  int               testCount;
  int               failCount;
  logic             modelBusy;
  logic             modelBank;
  logic             modelPending;
  int               clrCnt;
  logic [PIX_W-1:0] lastData;

  function automatic int rdBase();
`ifdef DBUF_EN
    return modelBank ? DEPTH : 0;
`else
    return 0;
`endif
  endfunction

  function automatic int wrBase();
`ifdef DBUF_EN
    return modelBank ? 0 : DEPTH;
`else
    return 0;
`endif
  endfunction

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] want);
    testCount++;
    assert (got === want) else begin
      failCount++;
      $error("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      testCount++;
      failCount++;
      $error("[TB] FAIL %s: scoreboard empty", tag);
      return;
    end
    e = expQ.pop_front();
    compare({tag, " data_valid"}, 32'(bus.data_valid), 32'(e.v));
    compare({tag, " data"},       32'(bus.data),       32'(e.d));
    compare({tag, " busy"},       32'(bus.busy),       32'(modelBusy));
    compare({tag, " bank"},       32'(bus.bank),       32'(modelBank));
  endtask

  // One clock of stimulus; the expected read result is queued before the edge.
  task automatic applyStimulus(input logic rd, input int r, input int c,
                               input logic w, input int rw, input int cw,
                               input logic [PIX_W-1:0] dw, input logic cl,
                               input logic sw, input string tag);
    exp_t e;
    logic busyNow, rdIn, wrIn, wrEff;
    int   rdIdx, wrIdx;
    busyNow = modelBusy;
    rdIn    = (r < ROWS) && (c < COLS);
    wrIn    = (rw < ROWS) && (cw < COLS);
    rdIdx   = rdBase() + r * COLS + c;
    wrIdx   = wrBase() + rw * COLS + cw;
    wrEff   = w && wrIn && !busyNow;
    if (rd) begin
      e.v = 1'b1;
      if (!rdIn) e.d = '0;
      else if (wrEff && (wrIdx == rdIdx)) e.d = dw;
      else e.d = model[rdIdx];
      lastData = e.d;
    end else begin
      e.v = 1'b0;
      e.d = lastData;
    end
    expQ.push_back(e);

    bus.rd_en = rd;
    bus.row   = ROW_W'(r);
    bus.col   = COL_W'(c);
    bus.we    = w;
    bus.rowW  = ROW_W'(rw);
    bus.colW  = COL_W'(cw);
    bus.dataW = dw;
    bus.clr   = cl;
    bus.swap  = sw;
    @(posedge clk);
    #1;

    if (wrEff) model[wrIdx] = dw;
    if (busyNow) begin
      model[wrBase() + clrCnt] = CLR_VAL;
      clrCnt++;
      if (clrCnt == DEPTH) begin
        modelBusy = 1'b0;
`ifdef DBUF_EN
        if (modelPending || sw) modelBank = ~modelBank;
        modelPending = 1'b0;
`endif
      end
    end else if (cl) begin
      modelBusy = 1'b1;
      clrCnt    = 0;
    end
`ifdef DBUF_EN
    if (!busyNow && sw) modelBank = ~modelBank;
    else if (busyNow && sw && modelBusy) modelPending = 1'b1;
`endif
    checkOutput(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, '0, 1'b0, 1'b0, tag);
  endtask

  task automatic writePix(input int r, input int c, input logic [PIX_W-1:0] d);
    applyStimulus(1'b0, 0, 0, 1'b1, r, c, d, 1'b0, 1'b0, "write");
  endtask

  task automatic readPix(input int r, input int c, input string tag);
    applyStimulus(1'b1, r, c, 1'b0, 0, 0, '0, 1'b0, 1'b0, tag);
  endtask

  task automatic pulseClr();
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, '0, 1'b1, 1'b0, "clr pulse");
  endtask

  task automatic pulseSwap();
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, '0, 1'b0, 1'b1, "swap pulse");
  endtask

  // Runs while the DUT reports busy, bounded by maxCycles; extras injects a
  // second clr, a user write and a swap partway through.
  task automatic runClear(input int maxCycles, input logic extras, output int n);
    n = 0;
    for (int i = 0; i < maxCycles; i++) begin
      if (bus.busy !== 1'b1) break;
      n++;
      applyStimulus(1'b0, 0, 0, extras && (i == 5000), 0, 0, 1'b1,
                    extras && (i == 500), extras && (i == 6000), "clearing");
    end
  endtask

  initial begin
    int n;
    testCount    = 0;
    failCount    = 0;
    modelBusy    = 1'b0;
    modelBank    = 1'b0;
    modelPending = 1'b0;
    clrCnt       = 0;
    lastData     = '0;
    bus.rd_en = 1'b0; bus.row = '0; bus.col = '0;
    bus.we = 1'b0; bus.rowW = '0; bus.colW = '0; bus.dataW = '0;
    bus.clr = 1'b0; bus.swap = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    compare("reset data",       32'(bus.data),       32'd0);
    compare("reset data_valid", 32'(bus.data_valid), 32'd0);
    compare("reset busy",       32'(bus.busy),       32'd0);
    compare("reset bank",       32'(bus.bank),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bring every pixel to a known value before directed checks.
    pulseClr();
    runClear(DEPTH + 20, 1'b0, n);
`ifdef DBUF_EN
    pulseSwap();
    pulseClr();
    runClear(DEPTH + 20, 1'b0, n);
`endif

    writePix(0, 37, 1'b1);
    for (int c = 35; c <= 45; c++) readPix(0, c, "row0 read");
    idle("read hold");

    writePix(ROWS, 0, 1'b1);
    writePix((1 << ROW_W) - 1, (1 << COL_W) - 1, 1'b1);
    readPix(0, 0, "oor write dropped");
    readPix(ROWS, 0, "oor read row");
    readPix((1 << ROW_W) - 1, 3, "oor read top");
    writePix(ROWS - 1, COLS - 1, 1'b1);
    readPix(ROWS - 1, COLS - 1, "last pixel");

    applyStimulus(1'b1, 5, 5, 1'b1, 5, 5, 1'b1, 1'b0, 1'b0, "collision one");
    readPix(5, 5, "after collision");
    applyStimulus(1'b1, 5, 5, 1'b1, 5, 5, 1'b0, 1'b0, 1'b0, "collision zero");
    idle("collision hold");

`ifdef DBUF_EN
    writePix(2, 3, 1'b1);
    readPix(2, 3, "back bank hidden");
    pulseSwap();
    readPix(2, 3, "after swap");
`endif

    for (int a = 0; a < DEPTH; a++) writePix(a / COLS, a % COLS, 1'b1);
    pulseClr();
    runClear(DEPTH + 20, 1'b1, n);
    compare("busy cycle count", 32'(n), 32'(DEPTH));
    for (int a = 0; a < DEPTH; a++) readPix(a / COLS, a % COLS, "readback");
    idle("readback hold");

    for (int a = 0; a < 300; a++) writePix(a / COLS, a % COLS, 1'b1);
    readPix(0, 0, "pre-clear read");
    pulseClr();
    runClear(100, 1'b0, n);
    compare("partial clear cycles", 32'(n), 32'd100);
    #1;
    rst_n = 1'b0;
    #1;
    compare("async reset busy",       32'(bus.busy),       32'd0);
    compare("async reset data",       32'(bus.data),       32'd0);
    compare("async reset data_valid", 32'(bus.data_valid), 32'd0);
    compare("async reset bank",       32'(bus.bank),       32'd0);
    modelBusy    = 1'b0;
    modelBank    = 1'b0;
    modelPending = 1'b0;
    lastData     = '0;
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 300; a++) readPix(a / COLS, a % COLS, "partial clear");
    idle("final");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
